// File: rtl/lsu_bus_master_pkg.sv
// Shared types and helpers for the load/store bus master: funct3 encodings,
// FSM states and the store-side lane mask/data builders.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  // Misaligned access or a funct3 with no RV32 load/store meaning.
  function automatic logic lsu_req_err(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_B, LSU_BU: return 1'b0;
      LSU_H, LSU_HU: return a[0];
      LSU_W:         return a != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lsu_store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_B, LSU_BU: return 4'b0001 << a;
      LSU_H, LSU_HU: return a[1] ? 4'b1100 : 4'b0011;
      default:       return MASK_ALL;
    endcase
  endfunction

  function automatic logic [31:0] lsu_store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      LSU_B, LSU_BU: return {4{wd[7:0]}};
      LSU_H, LSU_HU: return {2{wd[15:0]}};
      default:       return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Core request/response handshake plus data-memory bus, grouped for the
// load/store bus master (master modport) and its environment (slave modport).
interface lsu_bus_master_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] bus_address;
  logic [31:0]       bus_data_out;
  logic              bus_rd_wr_en;
  logic              bus_cs;
  logic [3:0]        bus_mask;
  logic [31:0]       bus_data_in;
  logic              bus_valid;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  bus_data_in, bus_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_address, bus_data_out, bus_rd_wr_en, bus_cs, bus_mask
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output bus_data_in, bus_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_address, bus_data_out, bus_rd_wr_en, bus_cs, bus_mask
  );

endinterface

// File: rtl/lsu_bus_master_load_extract.sv
// Combinational load-lane extraction: selects the addressed byte/half/word
// of a 32-bit memory word and sign- or zero-extends it per funct3.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      LSU_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  data_o = {24'h000000, byte_sel};
      LSU_H:   data_o = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  data_o = {16'h0000, half_sel};
      LSU_W:   data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus master: one RV32 access at a time, fully registered bus and
// response outputs. Define LSU_TIMEOUT_EN to abort loads stuck in WAIT.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_bus_master_if.master bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  lsu_state_e        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] bus_address_q, bus_address_d;
  logic [31:0]       bus_data_out_q, bus_data_out_d;
  logic              bus_cs_q, bus_cs_d;
  logic              bus_rd_wr_en_q, bus_rd_wr_en_d;
  logic [3:0]        bus_mask_q, bus_mask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  lsu_load_extract u_extract (
    .word_i   (bus.bus_data_in),
    .addr_i   (addr_lo_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  // Registers are loaded with the value they must show in the next state,
  // so bus_cs/mask/rd_wr_en are valid exactly for the ISSUE cycle.
  always_comb begin
    state_d        = state_q;
    addr_lo_d      = addr_lo_q;
    we_d           = we_q;
    f3_d           = f3_q;
    bus_address_d  = bus_address_q;
    bus_data_out_d = bus_data_out_q;
    bus_cs_d       = 1'b0;
    bus_rd_wr_en_d = 1'b0;
    bus_mask_d     = '0;
    rsp_valid_d    = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_rdata_d    = '0;
`ifdef LSU_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_lo_d = bus.req_addr[1:0];
          we_d      = bus.req_we;
          f3_d      = bus.req_funct3;
          if (lsu_req_err(bus.req_funct3, bus.req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d        = ST_ISSUE;
            bus_cs_d       = 1'b1;
            bus_rd_wr_en_d = bus.req_we;
            bus_address_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (bus.req_we) begin
              bus_mask_d     = lsu_store_mask(bus.req_funct3, bus.req_addr[1:0]);
              bus_data_out_d = lsu_store_data(bus.req_funct3, bus.req_wdata);
            end
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (bus.bus_valid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_lo_q      <= '0;
      we_q           <= 1'b0;
      f3_q           <= '0;
      bus_address_q  <= '0;
      bus_data_out_q <= '0;
      bus_cs_q       <= 1'b0;
      bus_rd_wr_en_q <= 1'b0;
      bus_mask_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      addr_lo_q      <= addr_lo_d;
      we_q           <= we_d;
      f3_q           <= f3_d;
      bus_address_q  <= bus_address_d;
      bus_data_out_q <= bus_data_out_d;
      bus_cs_q       <= bus_cs_d;
      bus_rd_wr_en_q <= bus_rd_wr_en_d;
      bus_mask_q     <= bus_mask_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.bus_address  = bus_address_q;
  assign bus.bus_data_out = bus_data_out_q;
  assign bus.bus_cs       = bus_cs_q;
  assign bus.bus_rd_wr_en = bus_rd_wr_en_q;
  assign bus.bus_mask     = bus_mask_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: byte-addressed reference memory,
// directed scenarios and randomized load/store traffic.
module tb_lsu_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_hold = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lsu_bus_master_if #(.ADDR_W(32)) bif ();

  lsu_bus_master #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Memory responder: writes on negedge, read data valid the cycle after a sampled read.
  logic [31:0] mem_w [int unsigned];
  logic [7:0]  ref_b [int unsigned];
  logic        rd_pend;
  logic [31:0] rd_data = 32'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k = int'(a >> 2);
    return mem_w.exists(k) ? mem_w[k] : 32'h0;
  endfunction

  always @(negedge clk) begin : mem_write
    logic [31:0] t;
    if (rst_n && bif.bus_cs && bif.bus_rd_wr_en) begin
      t = mem_rd(bif.bus_address);
      for (int i = 0; i < 4; i++)
        if (bif.bus_mask[i]) t[8*i +: 8] = bif.bus_data_out[8*i +: 8];
      mem_w[int'(bif.bus_address >> 2)] = t;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else if (bif.bus_cs && !bif.bus_rd_wr_en) begin
      rd_pend <= 1'b1;
      rd_data <= mem_rd(bif.bus_address);
    end else if (bif.bus_valid) rd_pend <= 1'b0;
  end

  assign bif.bus_valid   = rd_pend & ~mem_hold;
  assign bif.bus_data_in = rd_data;

  // Reference model over a byte-addressed memory.
  function automatic int unsigned f_sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit f_err(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    return (a % f_sz(f3)) != 0;
  endfunction

  function automatic logic [7:0] ref_get(input logic [31:0] a);
    return ref_b.exists(int'(a)) ? ref_b[int'(a)] : 8'h00;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = f_sz(f3);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < s; i++) v = v | (32'(ref_get(a + i)) << (8 * i));
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~((32'd1 << (8 * s)) - 32'd1);
    return v;
  endfunction

  function automatic void f_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int unsigned i = 0; i < f_sz(f3); i++) ref_b[int'(a + i)] = wd[8*i +: 8];
  endfunction

  function automatic logic [3:0] f_mask(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((32'd1 << f_sz(f3)) - 32'd1) << (a % 4));
  endfunction

  function automatic logic [31:0] f_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    for (int unsigned i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % f_sz(f3)) +: 8];
    return d;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    mem_w[int'(a >> 2)] = w;
    for (int unsigned i = 0; i < 4; i++) ref_b[int'(a + i)] = w[8*i +: 8];
  endtask

  // Drives one request and observes the bus/response; lat = -1 if no response in max_cyc.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int max_cyc,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int cs_cnt, output logic [3:0] m, output logic [31:0] d,
                        output logic w, output logic [31:0] a, output int rdy_busy,
                        output int wt);
    lat = -1; rdata = '0; err = 1'b0; cs_cnt = 0; m = '0; d = '0; w = 1'b0; a = '0;
    rdy_busy = 0; wt = 0;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_funct3 = f3;
    bif.req_addr = addr; bif.req_wdata = wd;
    while (!bif.req_ready && wt < 50) begin @(negedge clk); wt++; end
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) bif.req_valid = 1'b0;
      if (bif.req_ready) rdy_busy++;
      if (bif.bus_cs) begin
        cs_cnt++; m = bif.bus_mask; d = bif.bus_data_out;
        w = bif.bus_rd_wr_en; a = bif.bus_address;
      end
      if (bif.rsp_valid) begin lat = c; rdata = bif.rsp_rdata; err = bif.rsp_err; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_tests++; if (bif.bus_cs !== 1'b0) begin n_fail++; $display("FAIL reset_bus_cs got %h exp 0", bif.bus_cs); end
    n_tests++; if (bif.bus_rd_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_wr_en got %h exp 0", bif.bus_rd_wr_en); end
    n_tests++; if (bif.bus_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask got %h exp 0", bif.bus_mask); end
    n_tests++; if (bif.bus_address !== 32'h0) begin n_fail++; $display("FAIL reset_address got %h exp 0", bif.bus_address); end
    n_tests++; if (bif.bus_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", bif.bus_data_out); end
    n_tests++; if (bif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %h exp 0", bif.rsp_valid); end
    n_tests++; if (bif.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %h exp 0", bif.rsp_err); end
    n_tests++; if (bif.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", bif.rsp_rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %h exp 1", bif.req_ready); end
  endtask

  task automatic test_store_byte;
    int lat, cs, rb, wt; logic [31:0] rd, d, a; logic e, w; logic [3:0] m;
    do_req(1'b1, 3'b000, 32'h102, 32'h000000AB, 10, lat, rd, e, cs, m, d, w, a, rb, wt);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL sb_latency got %0d exp 2", lat); end
    n_tests++; if (m !== 4'b0100) begin n_fail++; $display("FAIL sb_mask got %b exp 0100", m); end
    n_tests++; if (d !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_data got %h exp ababab ab", d); end
    n_tests++; if (w !== 1'b1) begin n_fail++; $display("FAIL sb_rd_wr_en got %h exp 1", w); end
    n_tests++; if (a !== 32'h100) begin n_fail++; $display("FAIL sb_address got %h exp 100", a); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL sb_err got %h exp 0", e); end
    n_tests++; if (cs != 1) begin n_fail++; $display("FAIL sb_cs_cycles got %0d exp 1", cs); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] exs [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234, 32'h80FF1234};
    int lat, cs, rb, wt; logic [31:0] rd, d, a; logic e, w; logic [3:0] m;
    preload(32'h100, 32'h80FF1234);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], ads[i], 32'h0, 10, lat, rd, e, cs, m, d, w, a, rb, wt);
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL load%0d_latency got %0d exp 3", i, lat); end
      n_tests++; if (rd !== exs[i]) begin n_fail++; $display("FAIL load%0d_rdata got %h exp %h", i, rd, exs[i]); end
      n_tests++; if (e !== 1'b0 || m !== 4'h0 || w !== 1'b0) begin
        n_fail++; $display("FAIL load%0d_bus got err=%h mask=%h wr=%h exp 0 0 0", i, e, m, w); end
    end
  endtask

  task automatic test_errors;
    logic        wes [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{3'b010, 3'b011, 3'b101, 3'b001, 3'b111};
    logic [31:0] ads [5] = '{32'h101, 32'h100, 32'h103, 32'h101, 32'h104};
    int lat, cs, rb, wt; logic [31:0] rd, d, a; logic e, w; logic [3:0] m;
    for (int i = 0; i < 5; i++) begin
      do_req(wes[i], f3s[i], ads[i], 32'h12345678, 10, lat, rd, e, cs, m, d, w, a, rb, wt);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL err%0d_latency got %0d exp 1", i, lat); end
      n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err%0d_flag got %h exp 1", i, e); end
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err%0d_rdata got %h exp 0", i, rd); end
      n_tests++; if (cs != 0) begin n_fail++; $display("FAIL err%0d_cs_cycles got %0d exp 0", i, cs); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, cs, rb, wt; logic [31:0] rd, d, a; logic e, w; logic [3:0] m;
    do_req(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 10, lat, rd, e, cs, m, d, w, a, rb, wt);
    f_store(3'b010, 32'h200, 32'hDEADBEEF);
    n_tests++; if (lat != 2 || rb != 0) begin n_fail++; $display("FAIL b2b_sw got lat=%0d ready_busy=%0d exp 2 0", lat, rb); end
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 10, lat, rd, e, cs, m, d, w, a, rb, wt);
    n_tests++; if (wt != 0) begin n_fail++; $display("FAIL b2b_ready_wait got %0d exp 0", wt); end
    n_tests++; if (lat != 3 || rb != 0) begin n_fail++; $display("FAIL b2b_lw got lat=%0d ready_busy=%0d exp 3 0", lat, rb); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_lw_rdata got %h exp deadbeef", rd); end
  endtask

  task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
    int lat, cs, rb, wt; logic [31:0] rd, d, a; logic e, w; logic [3:0] m;
    mem_hold = 1'b1;
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 40, lat, rd, e, cs, m, d, w, a, rb, wt);
    n_tests++; if (lat != 18) begin n_fail++; $display("FAIL timeout_latency got %0d exp 18", lat); end
    n_tests++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp got err=%h rdata=%h exp 1 0", e, rd); end
    mem_hold = 1'b0;
    repeat (3) @(negedge clk);
`else
    int seen = 0; int lat = -1; logic [31:0] rd = '0; logic e = 1'b0;
    mem_hold = 1'b1;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_funct3 = 3'b010; bif.req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk); bif.req_valid = 1'b0;
    repeat (99) begin @(negedge clk); if (bif.rsp_valid) seen++; end
    n_tests++; if (seen != 0 || bif.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL wait_hold got rsp=%0d ready=%h exp 0 0", seen, bif.req_ready); end
    mem_hold = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bif.rsp_valid) begin lat = c; rd = bif.rsp_rdata; e = bif.rsp_err; break; end
    end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL wait_release_latency got %0d exp 1", lat); end
    n_tests++; if (rd !== 32'h80FF1234 || e !== 1'b0) begin
      n_fail++; $display("FAIL wait_release_rsp got %h err=%h exp 80ff1234 0", rd, e); end
`endif
  endtask

  task automatic test_reset_mid;
    int seen, rdy_lo;
    for (int ph = 1; ph <= 2; ph++) begin
      mem_hold = 1'b1;
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_funct3 = 3'b010; bif.req_addr = 32'h104;
      @(posedge clk);
      for (int k = 1; k <= ph; k++) begin @(negedge clk); bif.req_valid = 1'b0; end
      if (ph == 1) begin
        n_tests++; if (bif.bus_cs !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue_cs got %h exp 1", bif.bus_cs); end
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bif.bus_cs !== 1'b0 || bif.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid%0d_async got cs=%h rsp=%h exp 0 0", ph, bif.bus_cs, bif.rsp_valid); end
      @(negedge clk); rst_n = 1'b1; mem_hold = 1'b0;
      seen = 0; rdy_lo = 0;
      repeat (6) begin
        @(negedge clk);
        if (bif.rsp_valid) seen++;
        if (!bif.req_ready) rdy_lo++;
      end
      n_tests++; if (seen != 0 || rdy_lo != 0) begin
        n_fail++; $display("FAIL rstmid%0d_after got rsp=%0d ready_low=%0d exp 0 0", ph, seen, rdy_lo); end
    end
  endtask

  task automatic test_random;
    int lat, cs, rb, wt, exp_lat; logic [31:0] rd, d, a, exp_rd, addr, wd;
    logic e, w, we, exp_e; logic [3:0] m; logic [2:0] f3;
    for (int i = 0; i < 4; i++) preload(32'h300 + 32'(4 * i), $urandom);
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      addr = 32'h300 + 32'($urandom_range(0, 15)); wd = $urandom;
      exp_e = f_err(f3, addr);
      exp_lat = exp_e ? 1 : (we ? 2 : 3);
      exp_rd = (exp_e || we) ? 32'h0 : f_load(f3, addr);
      do_req(we, f3, addr, wd, 10, lat, rd, e, cs, m, d, w, a, rb, wt);
      n_tests++; if (lat != exp_lat || e !== exp_e) begin
        n_fail++; $display("FAIL rnd%0d_timing got lat=%0d err=%h exp %0d %h", n, lat, e, exp_lat, exp_e); end
      n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rd, exp_rd); end
      n_tests++; if (cs != (exp_e ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_cs_cycles got %0d exp %0d", n, cs, exp_e ? 0 : 1); end
      if (!exp_e) begin
        n_tests++; if (a !== (addr & ~32'h3) || w !== we) begin
          n_fail++; $display("FAIL rnd%0d_addr got %h wr=%h exp %h %h", n, a, w, addr & ~32'h3, we); end
        n_tests++; if (m !== (we ? f_mask(f3, addr) : 4'h0)) begin
          n_fail++; $display("FAIL rnd%0d_mask got %b exp %b", n, m, we ? f_mask(f3, addr) : 4'h0); end
        if (we) begin
          n_tests++; if (d !== f_lanes(f3, wd)) begin n_fail++; $display("FAIL rnd%0d_wdata got %h exp %h", n, d, f_lanes(f3, wd)); end
          f_store(f3, addr, wd);
        end
      end
    end
  endtask

  initial begin
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_funct3 = 3'b000;
    bif.req_addr = 32'h0; bif.req_wdata = 32'h0;
    test_reset;
    test_store_byte;
    test_load_ext;
    test_errors;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
